// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  function automatic int rf_depth(input int regbits);
    return 1 << regbits;
  endfunction

  // LSB positions of a port's field inside the packed address/data buses
  function automatic int addr_lsb(input int port, input int regbits);
    return port * regbits;
  endfunction

  function automatic int data_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits; a lock (new producer) wins over a landing writeback.
module regfile_scoreboard #(
  parameter int DEPTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_set,
  input  logic [REGBITS-1:0] i_set_addr,
  input  logic               i_clr,
  input  logic [REGBITS-1:0] i_clr_addr,
  output logic [DEPTH-1:0]   o_pending
);

  logic [DEPTH-1:0] r_pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (i_set && (i_set_addr == REGBITS'(k))) begin
          r_pending[k] <= 1'b1;
        end else if (i_clr && (i_clr_addr == REGBITS'(k))) begin
          r_pending[k] <= 1'b0;
        end
      end
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write bypass, post-reset clear sweep
// and a pending scoreboard for operand stalls.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int REGBITS  = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     ready,
  input  logic                     regwrite,
  input  logic [REGBITS-1:0]       wa,
  input  logic [WIDTH-1:0]         wd,
  input  logic                     lock,
  input  logic [REGBITS-1:0]       lock_addr,
  input  logic [NREAD*REGBITS-1:0] ra,
  output logic [NREAD*WIDTH-1:0]   rd,
  output logic [NREAD-1:0]         rvalid
);

  localparam int DEPTH   = rf_depth(REGBITS);
  localparam bit ZERO_EN = (ZERO_REG != 0);

  rf_state_t          r_state;
  logic [REGBITS-1:0] r_ptr;
  logic               r_ready;
  logic [WIDTH-1:0]   r_mem [DEPTH];

  logic               w_run;
  logic               w_we;
  logic               w_lock;
  logic [DEPTH-1:0]   w_pending;

  assign w_run  = (r_state == RUN);
  assign w_we   = w_run && regwrite && !(ZERO_EN && (wa == '0));
  assign w_lock = w_run && lock && !(ZERO_EN && (lock_addr == '0));

  // Clear sweep: one register per cycle, RUN after the last address is zeroed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_ptr <= r_ptr + 1'b1;
          if (&r_ptr) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end
        end
        RUN: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= CLEAR;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_mem[r_ptr] <= '0;
    end else if (w_we) begin
      r_mem[wa] <= wd;
    end
  end

  regfile_scoreboard #(
    .DEPTH   (DEPTH),
    .REGBITS (REGBITS)
  ) u_scoreboard (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_set      (w_lock),
    .i_set_addr (lock_addr),
    .i_clr      (w_we),
    .i_clr_addr (wa),
    .o_pending  (w_pending)
  );

  assign ready = r_ready;

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [REGBITS-1:0] w_ra;
    logic [WIDTH-1:0]   w_rd;
    logic               w_rv;

    assign w_ra = ra[addr_lsb(i, REGBITS) +: REGBITS];

    always_comb begin
      w_rd = '0;
      w_rv = 1'b0;
      if (w_run) begin
        if (ZERO_EN && (w_ra == '0)) begin
          w_rd = '0;
          w_rv = 1'b1;
        end else if (regwrite && (wa == w_ra)) begin
          w_rd = wd;
          w_rv = 1'b1;
        end else begin
          w_rd = r_mem[w_ra];
          w_rv = !w_pending[w_ra];
        end
      end
    end

    assign rd[data_lsb(i, WIDTH) +: WIDTH] = w_rd;
    assign rvalid[i]                       = w_rv;
  end

endmodule
